// File: rtl/sync_up_counter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : sync_up_counter_pkg                                              |
// | Purpose : Shared width helpers and boolean constants for the counter.      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef SYNC_UP_COUNTER_W
`define SYNC_UP_COUNTER_W(n) ((n) + 1)
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package sync_up_counter_pkg;

  localparam int DEFAULT_N = 3;

  function automatic int count_width(input int n);
    return `SYNC_UP_COUNTER_W(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_up_counter_if.sv
// +----------------------------------------------------------------------------+
// | Module  : sync_up_counter_if                                               |
// | Purpose : Bundles the clear input and count outputs of one counter.        |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sync_up_counter_if
  import sync_up_counter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input wire logic clk
);

  logic         clr;
  logic [N:0]   count;
  logic [N:0]   count_gray;
  logic         tc;
  logic         wrap;

  // Master drives the clear and observes the counter; slave is the counter.
  modport master (
    input  clk,
    output clr,
    input  count,
    input  count_gray,
    input  tc,
    input  wrap
  );

  modport slave (
    input  clk,
    input  clr,
    output count,
    output count_gray,
    output tc,
    output wrap
  );

endinterface

`default_nettype wire

// File: rtl/sync_up_counter_bin2gray.sv
// +----------------------------------------------------------------------------+
// | Module  : sync_up_counter_bin2gray                                         |
// | Purpose : Combinational binary-to-Gray conversion of arbitrary width.      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_up_counter_bin2gray #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] bin,
  output logic      [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

`default_nettype wire

// File: rtl/sync_up_counter.sv
// +----------------------------------------------------------------------------+
// | Module  : sync_up_counter                                                  |
// | Purpose : Free-running (N+1)-bit up-counter with registered Gray copy,     |
// |           terminal-count flag and registered wrap pulse.                   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_up_counter
  import sync_up_counter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  wire logic       clk,
  input  wire logic       clr,
  output logic      [N:0] count,
  output logic      [N:0] count_gray,
  output logic            tc,
  output logic            wrap
);

  localparam int W = count_width(N);

  logic [N:0] r_count;
  logic [N:0] r_count_gray;
  logic       r_wrap;
  logic [N:0] w_count_next;
  logic [N:0] w_gray_next;
  logic       w_tc;

  assign w_count_next = r_count + W'(1);
  assign w_tc         = &r_count;

  // Gray is computed from the next binary value so it lands in the same cycle as count.
  sync_up_counter_bin2gray #(
    .WIDTH (W)
  ) u_bin2gray (
    .bin  (w_count_next),
    .gray (w_gray_next)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count      <= '0;
      r_count_gray <= '0;
      r_wrap       <= `FALSE;
    end else begin
      r_count      <= w_count_next;
      r_count_gray <= w_gray_next;
      r_wrap       <= w_tc;
    end
  end

  assign count      = r_count;
  assign count_gray = r_count_gray;
  assign tc         = w_tc;
  assign wrap       = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_sync_up_counter.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_sync_up_counter                                               |
// | Purpose : Directed self-checking bench for sync_up_counter (N = 3, 0, 7).  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sync_up_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  sync_up_counter_if #(.N(3)) c3_if (.clk(clk));
  sync_up_counter_if #(.N(0)) c0_if (.clk(clk));
  sync_up_counter_if #(.N(7)) c7_if (.clk(clk));

  sync_up_counter #(.N(3)) dut3 (
    .clk        (clk),
    .clr        (c3_if.clr),
    .count      (c3_if.count),
    .count_gray (c3_if.count_gray),
    .tc         (c3_if.tc),
    .wrap       (c3_if.wrap)
  );

  sync_up_counter #(.N(0)) dut0 (
    .clk        (clk),
    .clr        (c0_if.clr),
    .count      (c0_if.count),
    .count_gray (c0_if.count_gray),
    .tc         (c0_if.tc),
    .wrap       (c0_if.wrap)
  );

  sync_up_counter #(.N(7)) dut7 (
    .clk        (clk),
    .clr        (c7_if.clr),
    .count      (c7_if.count),
    .count_gray (c7_if.count_gray),
    .tc         (c7_if.tc),
    .wrap       (c7_if.wrap)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gray_of(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full check of the 4-bit counter against a hand-supplied count and wrap.
  task automatic check3(input string tag, input int exp_cnt, input logic exp_wrap);
    check({tag, "_count"}, 32'(c3_if.count), 32'(exp_cnt));
    check({tag, "_gray"},  32'(c3_if.count_gray), gray_of(32'(exp_cnt)));
    check({tag, "_tc"},    32'(c3_if.tc), (exp_cnt == 15) ? 32'd1 : 32'd0);
    check({tag, "_wrap"},  32'(c3_if.wrap), 32'(exp_wrap));
  endtask

  int exp_seq  [4] = '{1, 2, 3, 4};
  int exp_gray [4] = '{1, 3, 2, 6};

  initial begin
    int m0, m7, last0, last7;
    logic [7:0] prev7;
    logic [0:0] prev0;

    c3_if.clr = 1'b1;
    c0_if.clr = 1'b1;
    c7_if.clr = 1'b1;

    // Test 1: two clear edges, then count up from 0.
    step();
    step();
    check3("t1_reset", 0, 1'b0);
    c3_if.clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_seq_count", 32'(c3_if.count), 32'(exp_seq[i]));
      check("t1_seq_gray",  32'(c3_if.count_gray), 32'(exp_gray[i]));
    end

    // Test 2: count from 0 through 15 and wrap.
    c3_if.clr = 1'b1;
    step();
    check3("t2_clr", 0, 1'b0);
    c3_if.clr = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      check3("t2_run", i, 1'b0);
    end
    step();
    check3("t2_wrap_edge", 0, 1'b1);
    step();
    check3("t2_after_wrap", 1, 1'b0);

    // Test 3: clear mid-count at 5.
    for (int i = 2; i <= 5; i++) step();
    check3("t3_at5", 5, 1'b0);
    c3_if.clr = 1'b1;
    step();
    check3("t3_clr", 0, 1'b0);
    c3_if.clr = 1'b0;
    step();
    check3("t3_rel1", 1, 1'b0);
    step();
    check3("t3_rel2", 2, 1'b0);

    // Test 4: clear on the edge that would wrap.
    for (int i = 3; i <= 15; i++) step();
    check3("t4_at15", 15, 1'b0);
    c3_if.clr = 1'b1;
    step();
    check3("t4_clr_at15", 0, 1'b0);

    // Test 5: clear held for 10 edges.
    for (int i = 0; i < 10; i++) begin
      step();
      check3("t5_hold", 0, 1'b0);
    end
    c3_if.clr = 1'b0;
    step();
    check3("t5_release", 1, 1'b0);

    // Test 6: N = 0 and N = 7 wrap period and Gray single-bit steps.
    c0_if.clr = 1'b0;
    c7_if.clr = 1'b0;
    m0 = 0;
    m7 = 0;
    last0 = -1;
    last7 = -1;
    prev0 = 1'b0;
    prev7 = 8'h00;
    for (int i = 1; i <= 600; i++) begin
      step();
      m0 = (m0 + 1) & 1;
      m7 = (m7 + 1) & 255;
      check("n0_count", 32'(c0_if.count), 32'(m0));
      check("n0_gray",  32'(c0_if.count_gray), gray_of(32'(m0)));
      check("n0_tc",    32'(c0_if.tc), 32'(m0));
      check("n0_wrap",  32'(c0_if.wrap), (m0 == 0) ? 32'd1 : 32'd0);
      check("n0_onebit", 32'($countones(prev0 ^ c0_if.count_gray)), 32'd1);
      check("n7_count", 32'(c7_if.count), 32'(m7));
      check("n7_gray",  32'(c7_if.count_gray), gray_of(32'(m7)));
      check("n7_tc",    32'(c7_if.tc), (m7 == 255) ? 32'd1 : 32'd0);
      check("n7_wrap",  32'(c7_if.wrap), (m7 == 0) ? 32'd1 : 32'd0);
      check("n7_onebit", 32'($countones(prev7 ^ c7_if.count_gray)), 32'd1);
      if (c0_if.wrap === 1'b1) begin
        if (last0 >= 0) check("n0_period", 32'(i - last0), 32'd2);
        last0 = i;
      end
      if (c7_if.wrap === 1'b1) begin
        if (last7 >= 0) check("n7_period", 32'(i - last7), 32'd256);
        last7 = i;
      end
      prev0 = c0_if.count_gray;
      prev7 = c7_if.count_gray;
    end
    check("n7_wrap_seen", (last7 >= 0) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
